// File: rtl/uibi_arbiter.sv
// Two-master round-robin arbiter for the single UIBI master port.
// Registers the winning master's transaction, holds it on the bus until the slave acknowledges or the watchdog expires.
module uibi_arbiter #(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        m0_req,
  input  logic                        m0_wen,
  input  logic [2:0]                  m0_mode,
  input  logic [SLAVE_WIDTH-1:0]      m0_num,
  input  logic [XLEN-SLAVE_WIDTH-1:0] m0_addr,
  input  logic [XLEN-1:0]             m0_dat_i,
  output logic [XLEN-1:0]             m0_dat_o,
  output logic                        m0_ready,
  output logic                        m0_err,

  input  logic                        m1_req,
  input  logic                        m1_wen,
  input  logic [2:0]                  m1_mode,
  input  logic [SLAVE_WIDTH-1:0]      m1_num,
  input  logic [XLEN-SLAVE_WIDTH-1:0] m1_addr,
  input  logic [XLEN-1:0]             m1_dat_i,
  output logic [XLEN-1:0]             m1_dat_o,
  output logic                        m1_ready,
  output logic                        m1_err,

  output logic                        bus_req,
  output logic                        bus_wen,
  output logic [2:0]                  bus_mode,
  output logic [SLAVE_WIDTH-1:0]      bus_num,
  output logic [XLEN-SLAVE_WIDTH-1:0] bus_addr,
  output logic [XLEN-1:0]             bus_dat_o,
  input  logic [XLEN-1:0]             bus_dat_i,
  input  logic                        bus_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        grant_id;
  logic        last_grant;
  logic [15:0] watchdog;
  logic        winner;

  // NOTE: a combinational block assigns its output on every path so no latch is inferred.
  always_comb begin
    if (m0_req && m1_req) winner = ~last_grant;
    else                  winner = m1_req;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      watchdog   <= '0;
      bus_req    <= 1'b0;
      bus_wen    <= 1'b0;
      bus_mode   <= '0;
      bus_num    <= '0;
      bus_addr   <= '0;
      bus_dat_o  <= '0;
      m0_dat_o   <= '0;
      m0_ready   <= 1'b0;
      m0_err     <= 1'b0;
      m1_dat_o   <= '0;
      m1_ready   <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses; only BUSY raises them.
      m0_dat_o <= '0;
      m0_ready <= 1'b0;
      m0_err   <= 1'b0;
      m1_dat_o <= '0;
      m1_ready <= 1'b0;
      m1_err   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant_id <= winner;
            watchdog <= '0;
            bus_req  <= 1'b1;
            state    <= BUSY;
            if (winner) begin
              bus_wen   <= m1_wen;
              bus_mode  <= m1_mode;
              bus_num   <= m1_num;
              bus_addr  <= m1_addr;
              bus_dat_o <= m1_dat_i;
            end else begin
              bus_wen   <= m0_wen;
              bus_mode  <= m0_mode;
              bus_num   <= m0_num;
              bus_addr  <= m0_addr;
              bus_dat_o <= m0_dat_i;
            end
          end
        end

        BUSY: begin
          // A slave acknowledge beats a coincident watchdog expiry.
          if (bus_ready) begin
            if (grant_id) begin
              m1_dat_o <= bus_dat_i;
              m1_ready <= 1'b1;
            end else begin
              m0_dat_o <= bus_dat_i;
              m0_ready <= 1'b1;
            end
            bus_req <= 1'b0;
            state   <= DONE;
          end else if (watchdog == WD_LAST) begin
            if (grant_id) begin
              m1_ready <= 1'b1;
              m1_err   <= 1'b1;
            end else begin
              m0_ready <= 1'b1;
              m0_err   <= 1'b1;
            end
            bus_req <= 1'b0;
            state   <= DONE;
          end else if (watchdog != 16'hFFFF) begin
            watchdog <= watchdog + 16'd1;
          end
        end

        DONE: begin
          last_grant <= grant_id;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uibi_arbiter.sv
// Directed bench for uibi_arbiter: a scoreboard queue holds each expected transaction
// in grant order and is popped when a master's ready pulse appears.
module tb_uibi_arbiter;

  localparam int XLEN = 32;
  localparam int SW   = 4;
  localparam int AW   = XLEN - SW;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_wen, m1_req, m1_wen;
  logic [2:0]    m0_mode, m1_mode;
  logic [SW-1:0] m0_num, m1_num;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic          m0_ready, m0_err, m1_ready, m1_err;
  logic          bus_req, bus_wen, bus_ready;
  logic [2:0]    bus_mode;
  logic [SW-1:0] bus_num;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_dat_o, bus_dat_i;

  uibi_arbiter #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_mode(m0_mode), .m0_num(m0_num),
    .m0_addr(m0_addr), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_mode(m1_mode), .m1_num(m1_num),
    .m1_addr(m1_addr), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ready(m1_ready), .m1_err(m1_err),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_mode(bus_mode), .bus_num(bus_num),
    .bus_addr(bus_addr), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            id;
    logic          wen;
    logic [2:0]    mode;
    logic [SW-1:0] num;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    bit            err;
  } txn_t;

  txn_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a master's request and records the transaction it should produce.
  task automatic request(input bit id, input logic wen, input logic [2:0] mode,
                         input logic [SW-1:0] num, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input bit err);
    txn_t t;
    t.id = id; t.wen = wen; t.mode = mode; t.num = num; t.addr = addr;
    t.wdata = wdata; t.rdata = rdata; t.err = err;
    sb.push_back(t);
    if (id) begin
      m1_req = 1'b1; m1_wen = wen; m1_mode = mode; m1_num = num; m1_addr = addr; m1_dat_i = wdata;
    end else begin
      m0_req = 1'b1; m0_wen = wen; m0_mode = mode; m0_num = num; m0_addr = addr; m0_dat_i = wdata;
    end
  endtask

  // Plays the slave for the transaction at the head of the scoreboard.
  task automatic serve(input int waits, input bit never_ready, input logic [1:0] drop);
    txn_t e;
    int   n;
    int   cnt;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
      return;
    end
    e = sb[0];
    n = 0;
    while (!bus_req && n < 20) begin
      tick();
      n++;
    end
    check("grant_latency", n, 1);
    check("bus_num",   bus_num,   e.num);
    check("bus_addr",  bus_addr,  e.addr);
    check("bus_wen",   bus_wen,   e.wen);
    check("bus_mode",  bus_mode,  e.mode);
    check("bus_dat_o", bus_dat_o, e.wdata);
    if (never_ready) begin
      bus_dat_i = $urandom | 32'h1;
      cnt = 0;
      while (bus_req && cnt < 100) begin
        tick();
        cnt++;
      end
      check("timeout_busy_cycles", cnt, TO);
    end else begin
      for (int i = 0; i < waits; i++) begin
        if (i == 0) begin
          if (e.id) begin m1_addr = ~e.addr; m1_dat_i = ~e.wdata; end
          else      begin m0_addr = ~e.addr; m0_dat_i = ~e.wdata; end
        end
        tick();
        check("wait_bus_req",   bus_req,   1'b1);
        check("wait_bus_addr",  bus_addr,  e.addr);
        check("wait_bus_dat_o", bus_dat_o, e.wdata);
        check("wait_no_ready",  m0_ready | m1_ready, 1'b0);
      end
      bus_ready = 1'b1;
      bus_dat_i = e.rdata;
      tick();
      bus_ready = 1'b0;
      bus_dat_i = $urandom;
    end
    e = sb.pop_front();
    if (e.id) begin
      check("m1_ready", m1_ready, 1'b1);
      check("m1_dat_o", m1_dat_o, e.rdata);
      check("m1_err",   m1_err,   e.err);
      check("m0_quiet", {m0_ready, m0_err, m0_dat_o}, 34'h0);
    end else begin
      check("m0_ready", m0_ready, 1'b1);
      check("m0_dat_o", m0_dat_o, e.rdata);
      check("m0_err",   m0_err,   e.err);
      check("m1_quiet", {m1_ready, m1_err, m1_dat_o}, 34'h0);
    end
    check("bus_req_dropped", bus_req, 1'b0);
    if (drop[0]) m0_req = 1'b0;
    if (drop[1]) m1_req = 1'b0;
    tick();
    check("ready_single_pulse", {m0_ready, m1_ready, m0_err, m1_err}, 4'h0);
    check("dat_o_cleared", {m0_dat_o, m1_dat_o}, 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_wen = 0; m0_mode = 0; m0_num = 0; m0_addr = 0; m0_dat_i = 0;
    m1_req = 0; m1_wen = 0; m1_mode = 0; m1_num = 0; m1_addr = 0; m1_dat_i = 0;
    bus_ready = 0; bus_dat_i = 0;
    tick(); tick();
    check("rst_bus_req",  bus_req, 1'b0);
    check("rst_bus_regs", {bus_wen, bus_mode, bus_num, bus_addr, bus_dat_o}, 64'h0);
    check("rst_m_out",    {m0_ready, m0_err, m1_ready, m1_err}, 4'h0);
    check("rst_dat_o",    {m0_dat_o, m1_dat_o}, 64'h0);
    rst = 1'b0;

    // Zero-wait read by m0.
    request(1'b0, 1'b0, 3'b010, 4'h8, 28'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    serve(0, 1'b0, 2'b01);

    // bus_ready while idle must not produce a completion.
    bus_ready = 1'b1; bus_dat_i = 32'hA5A5A5A5;
    tick(); tick();
    check("idle_ready_ignored", {m0_ready, m1_ready, bus_req}, 3'b000);
    bus_ready = 1'b0;

    // Fresh reset, then both masters request continuously: m0, m1, m0, m1.
    rst = 1'b1; tick(); rst = 1'b0;
    request(1'b0, 1'b0, 3'b010, 4'h1, 28'h0000100, 32'h0,        32'h11111111, 1'b0);
    request(1'b1, 1'b1, 3'b001, 4'h2, 28'h0000200, 32'h22220000, 32'h22222222, 1'b0);
    request(1'b0, 1'b0, 3'b010, 4'h1, 28'h0000100, 32'h0,        32'h33333333, 1'b0);
    request(1'b1, 1'b1, 3'b001, 4'h2, 28'h0000200, 32'h22220000, 32'h44444444, 1'b0);
    serve(0, 1'b0, 2'b00);
    serve(0, 1'b0, 2'b00);
    serve(0, 1'b0, 2'b00);
    serve(0, 1'b0, 2'b11);

    // m1 write with three wait states; master inputs perturbed mid-transaction.
    request(1'b1, 1'b1, 3'b010, 4'h3, 28'h0000ABC, 32'h12345678, 32'h00000000, 1'b0);
    serve(3, 1'b0, 2'b10);

    // Unresponsive slave: watchdog aborts after TIMEOUT cycles with zero data.
    request(1'b0, 1'b0, 3'b000, 4'h5, 28'h0000123, 32'h0, 32'h0, 1'b1);
    serve(0, 1'b1, 2'b01);

    // Acknowledge on the final watchdog cycle: data returned, no error.
    request(1'b1, 1'b0, 3'b100, 4'hA, 28'h0FFFFFF, 32'h0, 32'hCAFEF00D, 1'b0);
    serve(TO - 1, 1'b0, 2'b10);

    // Reset during BUSY aborts silently; a tie afterwards goes to m0.
    m1_req = 1'b1; m1_num = 4'h6; m1_addr = 28'h0000777; m1_dat_i = 32'h0;
    tick(); tick();
    check("abort_busy_bus_req", bus_req, 1'b1);
    rst = 1'b1;
    tick();
    check("abort_bus_req",  bus_req, 1'b0);
    check("abort_bus_regs", {bus_wen, bus_mode, bus_num, bus_addr, bus_dat_o}, 64'h0);
    check("abort_no_ready", {m0_ready, m0_err, m1_ready, m1_err}, 4'h0);
    request(1'b0, 1'b0, 3'b010, 4'h7, 28'h0000070, 32'h0, 32'h70707070, 1'b0);
    request(1'b1, 1'b0, 3'b010, 4'h9, 28'h0000090, 32'h0, 32'h90909090, 1'b0);
    tick();
    check("abort_still_quiet", {m0_ready, m1_ready, bus_req}, 3'b000);
    rst = 1'b0;
    serve(0, 1'b0, 2'b01);
    serve(0, 1'b0, 2'b10);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
